// File: rtl/pc_gen_pipe.sv
// Fetch PC generator for the pipelined core: sequences the PC through a valid/ready
// handshake to IF and applies trap, branch/jump and halt redirects with one-cycle latency.
module pc_gen_pipe #(
  parameter int unsigned          ADDR_W     = 32,
  parameter int unsigned          XLEN       = 64,
  parameter logic [ADDR_W-1:0]    RESET_VEC  = 32'h8000_0000,
  parameter int unsigned          INST_BYTES = 4,
  parameter int unsigned          ALIGN_MASK = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [2:0]        ex_branch,
  input  logic              ex_zero,
  input  logic              ex_less,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic [XLEN-1:0]   ex_src1,
  input  logic [XLEN-1:0]   ex_imm,
  input  logic              trap_valid,
  input  logic [ADDR_W-1:0] trap_vec,
  input  logic              halt,
  output logic [ADDR_W-1:0] pc,
  output logic              pc_valid,
  input  logic              pc_ready,
  output logic              flush,
  output logic              misalign,
  output logic              halted
);

  localparam logic [ADDR_W-1:0] INC_C   = ADDR_W'(INST_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_C = ADDR_W'(ALIGN_MASK);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;

  logic              br_taken;
  logic              ex_taken;
  logic              tgt_aligned;
  logic [XLEN-1:0]   jalr_sum;
  logic [ADDR_W-1:0] target;
  logic              unused_bits;

  always_comb begin
    br_taken = 1'b0;
    case (ex_branch)
      3'b001, 3'b010: br_taken = 1'b1;
      3'b100:         br_taken = ex_zero;
      3'b101:         br_taken = !ex_zero;
      3'b110:         br_taken = ex_less;
      3'b111:         br_taken = !ex_less;
      default:        br_taken = 1'b0;
    endcase
  end

  // jalr adds at full operand width and keeps only the PC bits; others are pc-relative
  assign jalr_sum    = ex_src1 + ex_imm;
  assign target      = (ex_branch == 3'b010) ? {jalr_sum[ADDR_W-1:1], 1'b0}
                                             : ex_pc + ex_imm[ADDR_W-1:0];
  assign ex_taken    = ex_valid && br_taken;
  assign tgt_aligned = (target & ALIGN_C) == '0;
  assign unused_bits = ^jalr_sum;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    flush    = 1'b0;
    misalign = 1'b0;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
        if (trap_valid) pc_d = trap_vec;
      end
      ST_RUN: begin
        misalign = ex_taken && !tgt_aligned;
        if (trap_valid) begin
          pc_d  = trap_vec;
          flush = 1'b1;
        end else if (ex_taken && tgt_aligned) begin
          pc_d  = target;
          flush = 1'b1;
        end else if (halt) begin
          state_d = ST_HALT;
          flush   = 1'b1;
        end else if (pc_ready) begin
          pc_d = pc_q + INC_C;
        end
      end
      ST_HALT: begin
        if (trap_valid) begin
          pc_d    = trap_vec;
          state_d = ST_RUN;
          flush   = 1'b1;
        end
      end
      default: state_d = ST_BOOT;
    endcase
    // a reset cycle must not leak redirect side effects upstream
    if (rst) begin
      flush    = 1'b0;
      misalign = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_VEC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign pc       = pc_q;
  assign pc_valid = (state_q == ST_RUN) && !rst;
  assign halted   = (state_q == ST_HALT) && !rst;

endmodule

// File: doc/pc_gen_pipe.md
Name: pc_gen_pipe

Overview:
- Parametrised successor to the single-cycle PC register, built for the pipelined core.
- Holds the fetch PC and offers it to IF through a valid/ready handshake.
- Resolves branch/jump redirects arriving late from EX, and trap redirects from the CSR unit.
- Tells upstream stages to flush younger instructions, and flags misaligned targets.

Parameters:
- ADDR_W, 32, PC width in bits; the output PC and all targets are truncated to this width.
- XLEN, 64, width of the src1/imm operands.
- RESET_VEC, 32'h80000000, PC value loaded on reset (ADDR_W bits).
- INST_BYTES, 4, sequential increment.
- ALIGN_MASK, 3, target bits that must be zero; 1 if the C extension is enabled.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- ex_valid  in  1  EX has a control-flow instruction this cycle.
- ex_branch  in  3  001 jal, 010 jalr, 100 beq, 101 bne, 110 blt, 111 bge; 000 means none.
- ex_zero  in  1  ALU zero flag.
- ex_less  in  1  ALU less flag.
- ex_pc  in  ADDR_W  PC of the EX instruction.
- ex_src1  in  XLEN  rs1 value.
- ex_imm  in  XLEN  sign-extended immediate.
- trap_valid  in  1  trap/mret redirect request.
- trap_vec  in  ADDR_W  trap target.
- halt  in  1  ebreak/halt request.
- pc  out  ADDR_W  current fetch PC.
- pc_valid  out  1  pc is presented to IF.
- pc_ready  in  1  IF accepts pc.
- flush  out  1  kill IF/ID contents; combinational, same cycle as the redirect.
- misalign  out  1  misaligned control-flow target detected; combinational.
- halted  out  1  block is in HALT.

Behaviour:
- Reset (rst=1 at an edge):
  - pc <= RESET_VEC; state <= BOOT; pc_valid=0, flush=0, misalign=0, halted=0.
  - Reset overrides every other input in the same cycle.
- States:
  - BOOT: pc_valid=0. Moves to RUN on the next edge with pc unchanged.
  - RUN: pc_valid=1.
  - HALT: pc_valid=0, halted=1. Left only by reset or trap_valid.
- Taken decode, only when ex_valid=1:
  - jal and jalr: always taken.
  - beq: taken if zero=1. bne: taken if zero=0.
  - blt: taken if less=1. bge: taken if less=0.
  - Codes 011 and 000: never taken.
- Target arithmetic:
  - jal and branches: (ex_pc + ex_imm[ADDR_W-1:0]) mod 2^ADDR_W.
  - jalr: (ex_src1 + ex_imm)[ADDR_W-1:0] with bit0 forced to 0.
  - Wrap-around beyond 2^ADDR_W is silently discarded.
- Misalignment:
  - If a taken target has (target & ALIGN_MASK) != 0: misalign=1, no redirect, no flush, pc keeps normal sequencing.
  - The CSR unit raises the trap.
- Priority in RUN, highest first:
  1. trap_valid: pc <= trap_vec; flush=1.
  2. Taken aligned EX redirect: pc <= target; flush=1.
  3. halt: state <= HALT; pc held; flush=1.
  4. pc_valid && pc_ready: pc <= pc + INST_BYTES.
  5. Otherwise: hold pc.
- Redirect independence:
  - Redirects ignore pc_ready; the old pc is dropped, never half-accepted.
  - The next cycle presents the new pc with pc_valid=1.
- Simultaneous events:
  - trap and branch together: trap wins, branch ignored.
  - Redirect and halt together: redirect wins, halt ignored.
- Other states:
  - trap_valid in HALT: pc <= trap_vec; state <= RUN; flush=1.
  - trap_valid in BOOT: pc <= trap_vec; state <= RUN.
  - ex_valid is ignored in BOOT and HALT.
- Handshake stability: while pc_valid=1 and pc_ready=0, pc must not change except by redirect.
- Sequential wrap: pc + INST_BYTES wraps modulo 2^ADDR_W (0xFFFFFFFC -> 0x00000000).
- Latency:
  - Redirect: input to new pc is 1 cycle.
  - Reset release to first pc_valid is 1 cycle.
- Reset mid-handshake or mid-halt: the next cycle is BOOT with RESET_VEC.
- DPI: report pc to the simulator on each accepted handshake.

Test Plan:
- Reset boot: hold rst 3 cycles, release, pc_ready=1 -> cycle+0 pc=0x80000000 valid=0; cycle+1 valid=1; then 0x80000004, 0x80000008.
- Backpressure: pc_ready=0 for 4 cycles at pc=0x80000008 -> pc stable, valid=1; ready=1 -> 0x8000000C next cycle.
- beq taken and not-taken:
  - Taken: ex_pc=0x80000010, imm=-8, zero=1 -> flush=1 same cycle, next pc=0x80000008.
  - Not taken: same with zero=0 -> no flush, sequential.
- jalr: src1=0x80001003, imm=2 -> target 0x80001004, flush=1.
- jalr misaligned: src1=0x80001001, imm=1 -> 0x80001002, misalign=1, no redirect.
- Priority: trap_valid (0x80000100) together with taken bne and halt -> pc=0x80000100, not halted.
- Halt: halt=1 -> halted=1 and valid=0 for 5 cycles; then trap_valid (0x80000200) -> RUN at 0x80000200.
- Wrap: pc=0xFFFFFFFC accepted -> next pc=0x00000000.
